// File: rtl/life_sequencer_if.sv
// ---------------------------------------------------------------------------
// life_sequencer_if
//
// Start/done handshake between the Life generation sequencer and the grid
// datapath that computes one evolution step.
//
// Signals:
//   dp_grid   grid presented to the datapath for evaluation
//   dp_start  one-cycle pulse: datapath evaluates dp_grid
//   dp_done   one-cycle pulse: dp_next is valid
//   dp_next   evolved grid returned by the datapath
//
// Modports:
//   master  sequencer side (drives dp_grid/dp_start)
//   slave   datapath side (drives dp_done/dp_next)
// ---------------------------------------------------------------------------
interface life_sequencer_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] dp_grid;
    logic             dp_start;
    logic             dp_done;
    logic [WIDTH-1:0] dp_next;

    modport master (
        output dp_grid,
        output dp_start,
        input  dp_done,
        input  dp_next
    );

    modport slave (
        input  dp_grid,
        input  dp_start,
        output dp_done,
        output dp_next
    );
endinterface

// File: rtl/life_sequencer.sv
// ---------------------------------------------------------------------------
// life_sequencer
//
// Generation scheduler for the Life grid datapath. Owns the current grid,
// loads it from a seed, paces free-run evolution with a programmable cycle
// divider, runs the datapath through a start/done handshake and counts
// generations. Supports free-run and single-step modes.
//
// Optional feature macro: LIFE_AUTO_HALT_EN
//   defined     : an evolution yielding a still life or an empty grid parks
//                 the sequencer in HALT until the next load.
//   not defined : still/extinct flags are reported but never stop evolution.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   load       level-sampled; capture seed into grid (ignored while busy)
//   seed       initial grid
//   run        free-run enable (level)
//   step       single-generation request (one-cycle pulse)
//   rate       clk cycles between generations in free-run (0 acts as 1)
//   dp         datapath handshake (master side): dp_grid, dp_start,
//              dp_done, dp_next
//   grid       current generation
//   gen_count  generations since last load (wraps)
//   busy       high while waiting on the datapath
//   still      last evolution returned an identical grid
//   extinct    grid is all zero after an evolution
// ---------------------------------------------------------------------------
module life_sequencer #(
    parameter int WIDTH = 64,
    parameter int DIV_W = 24,
    parameter int GEN_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [WIDTH-1:0]   seed,
    input  logic               run,
    input  logic               step,
    input  logic [DIV_W-1:0]   rate,
    life_sequencer_if.master   dp,
    output logic [WIDTH-1:0]   grid,
    output logic [GEN_W-1:0]   gen_count,
    output logic               busy,
    output logic               still,
    output logic               extinct
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_EVOLVE,
        S_HALT
    } state_t;

`ifdef LIFE_AUTO_HALT_EN
    localparam bit AUTO_HALT = 1'b1;
`else
    localparam bit AUTO_HALT = 1'b0;
`endif

    state_t           state;
    logic [DIV_W-1:0] divider;
    logic [DIV_W-1:0] rate_m1;
    logic             dp_start_q;
    logic             next_still;
    logic             next_extinct;
    logic             halt_now;

    // Terminal divider count. rate=0 behaves as rate=1, so the terminal
    // count is clamped at zero instead of underflowing to all ones.
    assign rate_m1 = (rate == '0) ? '0 : rate - DIV_W'(1);

    // Flags describing the generation the datapath is handing back.
    assign next_still   = (dp.dp_next == grid);
    assign next_extinct = (dp.dp_next == '0);
    assign halt_now     = AUTO_HALT && (next_still || next_extinct);

    // The datapath always sees the current generation directly.
    assign dp.dp_grid  = grid;
    assign dp.dp_start = dp_start_q;

    // NOTE: every register here is assigned with <= so all next-state terms
    // read the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            grid       <= '0;
            gen_count  <= '0;
            divider    <= '0;
            dp_start_q <= 1'b0;
            busy       <= 1'b0;
            still      <= 1'b0;
            extinct    <= 1'b0;
        end else begin
            // dp_start is a pulse: only the transition into EVOLVE raises it.
            dp_start_q <= 1'b0;

            // Load has priority over step/run everywhere except EVOLVE,
            // where the in-flight evaluation must be allowed to finish.
            if (load && (state != S_EVOLVE)) begin
                grid      <= seed;
                gen_count <= '0;
                still     <= 1'b0;
                extinct   <= 1'b0;
                divider   <= '0;
                state     <= S_IDLE;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (step) begin
                            state      <= S_EVOLVE;
                            dp_start_q <= 1'b1;
                            busy       <= 1'b1;
                        end else if (run) begin
                            state   <= S_WAIT;
                            divider <= '0;
                        end
                    end

                    S_WAIT: begin
                        if (!run) begin
                            state   <= S_IDLE;
                            divider <= '0;
                        end else if (divider == rate_m1) begin
                            state      <= S_EVOLVE;
                            divider    <= '0;
                            dp_start_q <= 1'b1;
                            busy       <= 1'b1;
                        end else begin
                            divider <= divider + DIV_W'(1);
                        end
                    end

                    S_EVOLVE: begin
                        // dp_done may arrive in the same cycle as dp_start
                        // when the datapath is purely combinational.
                        if (dp.dp_done) begin
                            grid      <= dp.dp_next;
                            gen_count <= gen_count + GEN_W'(1);
                            still     <= next_still;
                            extinct   <= next_extinct;
                            busy      <= 1'b0;
                            if (halt_now) begin
                                state <= S_HALT;
                            end else if (run) begin
                                state   <= S_WAIT;
                                divider <= '0;
                            end else begin
                                state <= S_IDLE;
                            end
                        end
                    end

                    S_HALT: begin
                        // Frozen until a load arrives.
                        state <= S_HALT;
                    end

                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/life_sequencer.md
# life_sequencer

Generation scheduler for the Life grid datapath. It owns the current grid register and loads it from a seed. It paces evolution with a programmable cycle divider, runs the datapath through a start/done handshake, and counts generations. Free-run and single-step modes are supported, and an optional auto-halt stops on still life or extinction. It sits between the seed source (LFSR or switch-selected seed) and the datapath, and replaces direct free-running evolution.

## Interface
Parameters:
- WIDTH, 64, grid bits (8x8 board)
- DIV_W, 24, width of rate divider
- GEN_W, 16, width of generation counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- load  in  1  level-sampled; capture seed into grid
- seed  in  WIDTH  initial grid
- run  in  1  free-run enable (level)
- step  in  1  single-generation request (one-cycle pulse)
- rate  in  DIV_W  clk cycles between generations in free-run
- dp_grid  out  WIDTH  grid presented to datapath (= grid)
- dp_start  out  1  one-cycle pulse: datapath evaluates dp_grid
- dp_done  in  1  one-cycle pulse: dp_next valid
- dp_next  in  WIDTH  evolved grid from datapath
- grid  out  WIDTH  current generation
- gen_count  out  GEN_W  generations since last load
- busy  out  1  high in EVOLVE
- still  out  1  last evolution produced identical grid
- extinct  out  1  grid is all zero after an evolution

## Operation
- States: IDLE, WAIT, EVOLVE, HALT.
- Reset (reset=0, async): state IDLE, grid=0, gen_count=0, divider=0, dp_start=0, busy=0, still=0, extinct=0.
- load=1 in IDLE/WAIT/HALT: grid<=seed, gen_count<=0, still/extinct<=0, divider<=0, next state IDLE. Load wins over step/run in the same cycle. Load in EVOLVE is ignored; the driver holds it until busy=0.
- IDLE: step=1 -> EVOLVE. Else run=1 -> WAIT with divider=0.
- WAIT: divider increments each cycle. run=0 -> IDLE and divider cleared. When divider == max(rate,1)-1 -> EVOLVE and divider cleared. rate=0 is treated as 1. step is ignored in WAIT.
- EVOLVE entry: dp_start=1 for exactly the first cycle; busy=1 throughout. Stay until dp_done=1. On dp_done:
  - grid<=dp_next and gen_count<=gen_count+1 (wraps modulo 2^GEN_W).
  - still<=(dp_next==grid) and extinct<=(dp_next==0).
  - Next state: HALT if the auto-halt condition holds; else WAIT if run=1; else IDLE.
- dp_done outside EVOLVE is ignored. dp_done coincident with dp_start is accepted (zero-latency combinational datapath).
- HALT: grid frozen, run/step ignored, exits only on load.
- reset deassertion mid-EVOLVE has no special handling: reset assertion at any time returns to the reset values immediately, and a late dp_done after reset is ignored.

## Timing
- dp_start asserts the cycle after the triggering step, or after the final WAIT count.
- Free-run period with a 1-cycle datapath: max(rate,1) WAIT cycles + EVOLVE cycles. With dp_done returned one cycle after dp_start: rate+2 cycles per generation.
- grid, gen_count, still and extinct update on the clk edge that samples dp_done and are visible the next cycle.
- All outputs are registered except dp_grid, which is a wire copy of grid.

## Configuration
- LIFE_AUTO_HALT_EN defined: EVOLVE completion with still=1 or extinct=1 enters HALT.
- Not defined: still/extinct flags still update, but HALT is unreachable and the sequencer keeps evolving per run/step.

## Test plan
- Reset then load seed=64'h0000_0000_0018_1800 (block), step pulse, datapath returns identical grid -> one dp_start, gen_count=1, still=1. With macro: HALT, further step gives no dp_start.
- Load blinker 64'h0000_0000_0038_0000, run=1, rate=4, dp_done 1 cycle after dp_start -> dp_start every 6 cycles, grid alternates, gen_count 1,2,3, still=0.
- rate=0 with run=1 -> behaves as rate=1: dp_start every 3 cycles; no divider underflow.
- load asserted while busy=1 with dp_done delayed 5 cycles -> load ignored, grid<=dp_next. Reasserted load in the next IDLE/WAIT cycle -> grid=seed, gen_count=0.
- gen_count at 16'hFFFF plus one evolution -> 16'h0000. Datapath returns all zero -> extinct=1 (HALT only with macro).
- reset driven low mid-EVOLVE, dp_done pulsed after release -> outputs at reset values, state IDLE, dp_done ignored.
